dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// default response latency and the byte-address fault-check widths.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;   // holds LATENCY-1 for LATENCY up to 15
  localparam int WORD_W          = 32;
  localparam int BYTE_ADDR_W     = 32;
  localparam int ALIGN_BITS      = 2;   // byte offset bits inside a 32-bit word

  // A byte address faults when it is not word aligned or lies above the array.
  function automatic logic addr_faulted(input logic [BYTE_ADDR_W-1:0] addr,
                                        input int                     word_aw);
    logic [BYTE_ADDR_W-1:0] upper;
    upper = addr >> (word_aw + ALIGN_BITS);
    return (addr[ALIGN_BITS-1:0] != '0) || (upper != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read. Contents are
// deliberately never reset so committed stores survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then issues a single-cycle response pulse.
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both 1; req_ready is high only in IDLE, requests seen while busy are
// dropped, and resp_valid is a one-cycle pulse with no back-pressure.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DMEM_DEPTH      = 1024,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int LATENCY         = DEFAULT_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0]      req_wdata,
  output logic                   resp_valid,
  output logic [WORD_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic                   busy,
  output state_t                 dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       wr_q;
  logic                       err_q;
  logic [DMEM_ADDR_WIDTH-1:0] idx_q;
  logic [WORD_W-1:0]          wdata_q;

  logic                       accept;
  logic                       commit;
  logic [WORD_W-1:0]          arr_rdata;

  assign accept = (state_q == ST_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= addr_faulted(req_addr, DMEM_ADDR_WIDTH);
        idx_q   <= req_addr[DMEM_ADDR_WIDTH+ALIGN_BITS-1:ALIGN_BITS];
        wdata_q <= req_wdata;
      end
    end
  end

  // The array access happens on the WAIT->RESP edge; a reset on that edge aborts it.
  assign commit = (state_q == ST_WAIT) && (cnt_q == '0) && reset_b && !err_q;

  dmem_array #(
    .DEPTH (DMEM_DEPTH),
    .AW    (DMEM_ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (commit && wr_q),
    .re_i    (commit && !wr_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_err    = (state_q == ST_RESP) && err_q;
  assign resp_rdata  = ((state_q == ST_RESP) && !wr_q && !err_q) ? arr_rdata : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 3, 1) driven by directed
// scenarios and random traffic, checked against a word-addressed memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_b    [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        busy       [3];
  state_t      dbg_state  [3];

  dmem_responder #(.DMEM_DEPTH(DEPTH), .DMEM_ADDR_WIDTH(AW), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset_b(reset_b[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]), .dbg_state_o(dbg_state[0]));

  dmem_responder #(.DMEM_DEPTH(DEPTH), .DMEM_ADDR_WIDTH(AW), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset_b(reset_b[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]), .dbg_state_o(dbg_state[1]));

  dmem_responder #(.DMEM_DEPTH(DEPTH), .DMEM_ADDR_WIDTH(AW), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_b(reset_b[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
    .busy(busy[2]), .dbg_state_o(dbg_state[2]));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [int];      // key = instance*4096 + word index
  logic [31:0] exp_q [$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (lat=%0d): observed %h expected %h", tag, lat_of(k), obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int k);
    chk({tag, "_ready"}, k, 32'(req_ready[k]), 32'd1);
    chk({tag, "_busy"}, k, 32'(busy[k]), 32'd0);
    chk({tag, "_rvalid"}, k, 32'(resp_valid[k]), 32'd0);
    chk({tag, "_rdata"}, k, resp_rdata[k], 32'd0);
    chk({tag, "_rerr"}, k, 32'(resp_err[k]), 32'd0);
  endtask

  // ---------------- driver ----------------
  // One full transaction; returns at the first idle cycle after the response.
  // With hold=1 req_valid stays high (with junk fields) through the busy window.
  task automatic run_req(input int k, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold);
    int          lat;
    int          n;
    int          key;
    bit          fault;
    logic [31:0] exp_rd;
    lat   = lat_of(k);
    fault = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    key   = k * 4096 + int'(addr / 4);
    if (fault || wr) exp_rd = 32'd0;
    else exp_rd = mdl.exists(key) ? mdl[key] : 32'd0;
    exp_q.push_back(exp_rd);

    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", k, 32'(req_ready[k]), 32'd1);

    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    @(negedge clk);
    req_valid[k] = hold;
    req_write[k] = 1'($urandom_range(0, 1));
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;

    for (int c = 1; c <= lat + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= lat) begin
        chk("wait_rvalid", k, 32'(resp_valid[k]), 32'd0);
        chk("wait_rdata", k, resp_rdata[k], 32'd0);
        chk("wait_rerr", k, 32'(resp_err[k]), 32'd0);
      end else begin
        chk("resp_rvalid", k, 32'(resp_valid[k]), 32'd1);
        chk("resp_rerr", k, 32'(resp_err[k]), 32'(fault));
        chk("resp_rdata", k, resp_rdata[k], exp_q.pop_front());
      end
      chk("busy_hi", k, 32'(busy[k]), 32'd1);
      chk("ready_lo", k, 32'(req_ready[k]), 32'd0);
    end
    if (wr && !fault) mdl[key] = wd;

    @(negedge clk);
    chk("post_ready", k, 32'(req_ready[k]), 32'd1);
    chk("post_busy", k, 32'(busy[k]), 32'd0);
    chk("post_rvalid", k, 32'(resp_valid[k]), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          key20;
    logic [31:0] addr;
    int          r;
    bit          hold;

    for (int k = 0; k < 3; k++) begin
      reset_b[k]   = 1'b0;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) reset_b[k] = 1'b1;
    for (int k = 0; k < 3; k++) chk_idle("reset", k);

    // Give every word the tests touch a known value.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        run_req(k, 1'b1, 32'(w * 4), $urandom, 1'b0);

    // Store then load.
    run_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    run_req(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    chk("deadbeef_model", 0, mdl[16'h0004], 32'hDEAD_BEEF);

    // Misaligned store must not disturb the word it overlaps.
    run_req(0, 1'b1, 32'h0000_0012, 32'hCAFE_F00D, 1'b0);
    run_req(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0);

    // Out-of-range load.
    run_req(0, 1'b0, 32'h0000_1000, 32'd0, 1'b0);

    // Back-to-back with req_valid held high across both requests.
    run_req(0, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
    run_req(0, 1'b1, 32'h0000_0014, 32'h0BAD_F00D, 1'b0);
    run_req(0, 1'b0, 32'h0000_0014, 32'd0, 1'b0);

    // Reset one cycle after accepting a store aborts it.
    key20 = 1 * 4096 + 8;
    while (req_ready[1] !== 1'b1) @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h0000_0020;
    req_wdata[1] = 32'h1234_5678;
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset_b[1]   = 1'b0;
    chk("abort_busy_before_reset", 1, 32'(busy[1]), 32'd1);
    @(negedge clk);
    reset_b[1] = 1'b1;
    chk_idle("abort", 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_resp", 1, 32'(resp_valid[1]), 32'd0);
    end
    chk("abort_model_old", 1, 32'(mdl[key20] != 32'h1234_5678), 32'd1);
    run_req(1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);

    // Minimum latency load.
    run_req(2, 1'b0, 32'h0000_0000, 32'd0, 1'b0);

    // Random traffic: aligned, misaligned and out-of-range, loads and stores.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 40; t++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (r == 1) addr = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        else             addr = 32'($urandom_range(0, 15) * 4);
        hold = (t != 39) && ($urandom_range(0, 3) == 0);
        run_req(k, 1'($urandom_range(0, 1)), addr, $urandom, hold);
      end
      req_valid[k] = 1'b0;
    end

    chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
